// File: rtl/clk_step_ctrl.sv
// CPU clock-enable generator (RUN / STEP / BURST / HALT) running on the board clock.
// It also debounces the button, stretches the CPU reset, and keeps a toggled clock and a wrapping tick counter.
module clk_step_ctrl #(
  parameter int DIV_WIDTH       = 26,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BURST_WIDTH     = 8,
  parameter int CNT_WIDTH       = 16,
  parameter int RST_HOLD        = 16
) (
  input  logic                   clk_signal,
  input  logic                   reset,
  input  logic                   btn,
  input  logic [1:0]             mode,
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   cpu_ce,
  output logic                   cpu_clk,
  output logic                   cpu_reset,
  output logic [CNT_WIDTH-1:0]   tick_count,
  output logic                   busy,
  output logic                   btn_db
);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RH_W = $clog2(RST_HOLD + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RH_W-1:0] RH_LAST = RH_W'(RST_HOLD);

  logic                   r_sync1, r_sync2;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_btn_db, r_btn_db_q;
  logic [1:0]             r_mode;
  logic [RH_W-1:0]        r_rst_cnt;
  logic                   r_cpu_reset;
  logic [DIV_WIDTH-1:0]   r_div_cnt;
  logic [BURST_WIDTH-1:0] r_remaining;
  logic                   r_busy;
  logic                   r_cpu_ce, r_cpu_clk;
  logic [CNT_WIDTH-1:0]   r_tick_count;

  logic w_press, w_mode_chg, w_hold, w_div_run, w_div_hit, w_div_over, w_tick;

  assign w_press    = r_btn_db & ~r_btn_db_q;
  // Compare against the incoming mode so the register load cycle itself is the quiet cycle.
  assign w_mode_chg = (mode != r_mode);
  assign w_hold     = r_cpu_reset | w_mode_chg;
  assign w_div_run  = (r_mode == MODE_RUN) | ((r_mode == MODE_BURST) & r_busy);
  assign w_div_hit  = (r_div_cnt == div);
  assign w_div_over = (r_div_cnt > div);

  always_comb begin
    w_tick = 1'b0;
    if (!w_hold) begin
      case (r_mode)
        MODE_RUN:   w_tick = w_div_hit;
        MODE_STEP:  w_tick = w_press;
        MODE_BURST: w_tick = r_busy & w_div_hit;
        default:    w_tick = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_signal) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_db_cnt   <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_q <= 1'b0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_btn_db_q <= r_btn_db;
      if (r_sync2 != r_btn_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_btn_db <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_signal) begin
    if (reset) begin
      r_cpu_reset <= 1'b1;
      r_rst_cnt   <= '0;
      r_mode      <= MODE_RUN;
    end else begin
      r_mode <= mode;
      if (r_cpu_reset) begin
        if (r_rst_cnt == RH_LAST) r_cpu_reset <= 1'b0;
        else                      r_rst_cnt   <= r_rst_cnt + RH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_signal) begin
    if (reset || w_hold || !w_div_run || w_div_hit || w_div_over) r_div_cnt <= '0;
    else                                                          r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
  end

  always_ff @(posedge clk_signal) begin
    if (reset || w_hold || (r_mode != MODE_BURST)) begin
      r_busy      <= 1'b0;
      r_remaining <= '0;
    end else if (r_busy) begin
      if (w_tick) begin
        r_remaining <= r_remaining - BURST_WIDTH'(1);
        if (r_remaining == BURST_WIDTH'(1)) r_busy <= 1'b0;
      end
    end else if (w_press && (burst_len != '0)) begin
      r_remaining <= burst_len;
      r_busy      <= 1'b1;
    end
  end

  always_ff @(posedge clk_signal) begin
    if (reset) begin
      r_cpu_ce     <= 1'b0;
      r_cpu_clk    <= 1'b0;
      r_tick_count <= '0;
    end else begin
      r_cpu_ce <= w_tick;
      if (w_tick) begin
        r_cpu_clk    <= ~r_cpu_clk;
        r_tick_count <= r_tick_count + CNT_WIDTH'(1);
      end
    end
  end

  assign cpu_ce     = r_cpu_ce;
  assign cpu_clk    = r_cpu_clk;
  assign cpu_reset  = r_cpu_reset;
  assign tick_count = r_tick_count;
  assign busy       = r_busy;
  assign btn_db     = r_btn_db;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: a reference model predicts every tick; a negedge monitor checks the DUT against it.
module tb_clk_step_ctrl;
  localparam int DB = 4;
  localparam int RH = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] div = 8'd3;
  logic [7:0] blen = 8'd0;
  logic       cpu_ce, cpu_clk, cpu_reset, busy, btn_db;
  logic [3:0] tick_count;

  clk_step_ctrl #(.DIV_WIDTH(8), .DEBOUNCE_CYCLES(DB), .BURST_WIDTH(8), .CNT_WIDTH(4), .RST_HOLD(RH)) dut (
    .clk_signal(clk), .reset(reset), .btn(btn), .mode(mode), .div(div), .burst_len(blen),
    .cpu_ce(cpu_ce), .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .tick_count(tick_count),
    .busy(busy), .btn_db(btn_db));

  always #5 clk = ~clk;

  typedef struct { int cyc; int cnt; bit clk; } ev_t;
  ev_t sb_q[$];
  int  ce_cyc[$];
  int  errors = 0, checks = 0, cyc = 0, ce_total = 0;
  bit  started = 0;

  // Reference model state: plain integers describing the behaviour, not the RTL's registers.
  int m_rst_left, m_s1, m_s2, m_db, m_dbp, m_run, m_phase, m_rem, m_busy, m_cnt;
  bit m_clk;
  logic [1:0] m_mode;

  task automatic div_step(output bit t);
    t = 0;
    if (m_phase == int'(div)) begin t = 1; m_phase = 0; end
    else if (m_phase > int'(div)) m_phase = 0;
    else m_phase++;
  endtask

  task automatic model_edge();
    bit press, chg, in_rst, tick;
    if (reset) begin
      m_rst_left = RH + 1;
      m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_run = 0;
      m_phase = 0; m_rem = 0; m_busy = 0; m_cnt = 0; m_clk = 0; m_mode = 2'b00;
      return;
    end
    press  = (m_db == 1) && (m_dbp == 0);
    chg    = (mode != m_mode);
    in_rst = (m_rst_left > 0);
    tick   = 0;
    if (in_rst || chg) begin
      m_phase = 0; m_busy = 0; m_rem = 0;
    end else begin
      case (m_mode)
        2'b00: div_step(tick);
        2'b01: begin tick = press; m_phase = 0; end
        2'b10: begin
          if (m_busy == 1) begin
            div_step(tick);
            if (tick) begin m_rem--; if (m_rem == 0) m_busy = 0; end
          end else begin
            m_phase = 0;
            if (press && blen != 0) begin m_rem = int'(blen); m_busy = 1; end
          end
        end
        default: m_phase = 0;
      endcase
    end
    if (tick) begin
      m_cnt = (m_cnt + 1) % 16;
      m_clk = !m_clk;
      sb_q.push_back('{cyc, m_cnt, m_clk});
    end
    if (m_rst_left > 0) m_rst_left--;
    m_dbp = m_db;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == DB) begin m_db = m_s2; m_run = 0; end
    end else m_run = 0;
    m_s2 = m_s1;
    m_s1 = int'(btn);
    m_mode = mode;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_edge();
      started = 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever cpu_ce is presented and checks the level outputs each cycle.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          checks++; errors++;
          $display("FAIL missed_tick: expected cpu_ce at cycle %0d, not observed", sb_q[0].cyc);
          void'(sb_q.pop_front());
        end
        if (cpu_ce) begin
          ce_total++;
          ce_cyc.push_back(cyc);
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tick: cpu_ce=1 at cycle %0d, no tick expected", cyc);
          end else begin
            e = sb_q.pop_front();
            if (e.cyc != cyc || e.cnt != int'(tick_count) || e.clk != cpu_clk) begin
              errors++;
              $display("FAIL tick_event: got cyc=%0d cnt=%0d clk=%0d expected cyc=%0d cnt=%0d clk=%0d",
                       cyc, tick_count, cpu_clk, e.cyc, e.cnt, e.clk);
            end
          end
        end
        check("state{rst,busy,db,clk,cnt}",
              {cpu_reset, busy, btn_db, cpu_clk, tick_count},
              {(m_rst_left > 0), m_busy[0], m_db[0], m_clk, m_cnt[3:0]});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ce(input int limit, output int waited);
    waited = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (cpu_ce) begin waited = k; break; end
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1; btn = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(8);
  endtask

  task automatic hold_btn(input logic v, input int n);
    btn = v;
    cycles(n);
  endtask

  initial begin
    int w, base, n;
    cycles(5);
    check("reset_outputs", {cpu_ce, cpu_clk, busy, btn_db, tick_count}, 0);
    check("reset_cpu_reset", cpu_reset, 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cpu_reset_stretch", cpu_reset, (i < 3) ? 1 : 0);
    end

    // RUN, div=3: 20 ticks four cycles apart, counter wraps once
    wait_ce(50, w);
    check("run_first_tick_seen", (w > 0) ? 1 : 0, 1);
    for (int k = 1; k < 20; k++) begin
      wait_ce(10, w);
      check("run_div3_gap", w, 4);
    end
    check("run_tick_count_wrap", tick_count, 4);
    check("run_cpu_clk_even", cpu_clk, 0);
    div = 8'd0;
    cycles(3);
    base = ce_total;
    cycles(8);
    check("run_div0_every_cycle", ce_total - base, 8);

    // STEP with a bouncy button
    mode = 2'b01;
    reset_pulse();
    base = ce_total;
    for (int b = 0; b < 3; b++) begin
      hold_btn(1'b1, 2);
      hold_btn(1'b0, 2);
    end
    btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 5) check("step_db_not_yet", btn_db, 0);
      if (k == 6) check("step_db_rise_at_6", btn_db, 1);
    end
    hold_btn(1'b0, 12);
    check("step_one_tick", ce_total - base, 1);
    hold_btn(1'b1, 10);
    hold_btn(1'b0, 12);
    check("step_two_ticks", ce_total - base, 2);
    check("step_tick_count", tick_count, 2);

    // BURST: 5 ticks three cycles apart; a second press mid-burst is ignored
    mode = 2'b10; div = 8'd2; blen = 8'd5;
    reset_pulse();
    base = ce_total;
    hold_btn(1'b1, 7);
    hold_btn(1'b0, 7);
    hold_btn(1'b1, 10);
    hold_btn(1'b0, 20);
    check("burst_five_ticks", ce_total - base, 5);
    n = ce_cyc.size();
    for (int k = n - 4; k < n; k++)
      if (k > 0) check("burst_gap", ce_cyc[k] - ce_cyc[k-1], 3);
    check("burst_busy_done", busy, 0);

    blen = 8'd0;
    base = ce_total;
    hold_btn(1'b1, 8);
    hold_btn(1'b0, 12);
    check("burst_len0_no_ticks", ce_total - base, 0);

    // Reset landing on the second tick of a burst
    blen = 8'd5;
    base = ce_total;
    btn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ce_total - base == 2) break;
    end
    reset = 1'b1; btn = 1'b0;
    @(negedge clk);
    check("rst_mid_burst_busy", busy, 0);
    check("rst_mid_burst_count", tick_count, 0);
    reset = 1'b0;
    cycles(40);
    check("rst_mid_burst_no_more", ce_total - base, 2);

    // RUN -> HALT -> RUN
    mode = 2'b00; div = 8'd7;
    reset_pulse();
    cycles(20);
    mode = 2'b11;
    base = ce_total;
    cycles(20);
    check("halt_no_ticks", ce_total - base, 0);
    mode = 2'b00;
    wait_ce(30, w);
    check("halt_to_run_latency", w, 9);

    // Randomized traffic against the model
    reset_pulse();
    n = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) blen = 8'($urandom_range(0, 6));
      if (n == 0) begin btn = ~btn; n = $urandom_range(1, 9); end
      else n--;
    end
    reset = 1'b0;
    cycles(5);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_step_ctrl.md
Name: clk_step_ctrl

Overview:
- Board-level CPU clock controller replacing the fixed toggle divider in front of the CPU core.
- Generates a one-cycle CPU clock enable from the 50 MHz board clock in one of four runtime modes: divided free-run, single-step, counted burst, halt.
- Debounces the push-button, stretches the CPU reset, counts issued ticks, and keeps a toggled clock output for legacy consumers.

Parameters:
- DIV_WIDTH, 26, width of the divider count and `div` port.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the debounced button changes (20 ms at 50 MHz).
- BURST_WIDTH, 8, width of `burst_len` and the internal remaining-tick counter.
- CNT_WIDTH, 16, width of `tick_count`.
- RST_HOLD, 16, cycles `cpu_reset` stays high after `reset` deasserts (minimum 1).

Ports:
- clk_signal  in  1  board clock, 50 MHz; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- btn  in  1  raw asynchronous push-button, active high.
- mode  in  2  00 RUN, 01 STEP, 10 BURST, 11 HALT.
- div  in  DIV_WIDTH  in RUN and BURST, one tick every div+1 cycles.
- burst_len  in  BURST_WIDTH  ticks issued per button press in BURST mode.
- cpu_ce  out  1  one-cycle clock-enable pulse (the "tick").
- cpu_clk  out  1  toggles on every tick.
- cpu_reset  out  1  stretched reset to the CPU.
- tick_count  out  CNT_WIDTH  number of ticks issued; wraps.
- busy  out  1  burst in progress.
- btn_db  out  1  debounced button level.

Behaviour:
- Reset (reset=1 at a clock edge) sets:
  - cpu_ce=0, cpu_clk=0, tick_count=0, busy=0, btn_db=0.
  - cpu_reset=1.
  - Divider, debounce counter, burst counter, synchronizer flops and mode register all cleared.
- Reset that arrives mid-burst or mid-debounce aborts that operation. Nothing is retained.
- cpu_reset:
  - Stays 1 while reset=1 and for exactly RST_HOLD cycles after the first cycle with reset=0.
  - Then goes 0.
  - While cpu_reset=1: cpu_ce is forced 0, and the divider and burst counters are held at 0.
- Button input path:
  - btn passes through a 2-flop synchronizer.
  - The debounce counter increments while the synchronized value differs from btn_db, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_db takes the synchronized value and the counter clears.
  - press = btn_db 0->1, as an internal single-cycle pulse.
  - Latency from btn to btn_db is 2 + DEBOUNCE_CYCLES cycles.
  - Bounces shorter than DEBOUNCE_CYCLES produce no press.
- Mode handling:
  - mode is registered each cycle.
  - When the registered mode changes, the divider and burst counters clear, busy drops, and no tick is issued that cycle.
- Divider:
  - Counts 0..div, then wraps to 0.
  - A tick is issued on the cycle the divider equals div.
  - div=0 gives a tick every cycle.
  - If div is changed below the current count, the next cycle wraps to 0 with no tick.
- Modes:
  - RUN: ticks come from the divider continuously.
  - STEP: each press produces exactly one tick, on the cycle after the press. The divider is idle.
  - BURST:
    - When not busy, a press loads remaining=burst_len, clears the divider and sets busy=1 (if burst_len≠0).
    - While busy, ticks come from the divider. Each tick decrements remaining.
    - busy clears on the cycle the last tick is issued.
    - A press while busy is ignored.
    - burst_len=0 produces no ticks and busy stays 0.
  - HALT: no ticks. Divider held at 0.
- Output registers:
  - cpu_ce is registered: it is high for exactly one cycle per tick.
  - cpu_clk toggles in the same cycle cpu_ce is high, so one cpu_clk rising edge occurs per two ticks.
  - tick_count increments on each tick and wraps from 2^CNT_WIDTH-1 to 0.
- Arithmetic: all counters are unsigned, with no saturation except as stated above.

Test Plan (bench uses DEBOUNCE_CYCLES=4, RST_HOLD=3, CNT_WIDTH=4):
- Reset checks:
  - reset held 5 cycles, then released -> cpu_reset=1 for 3 more cycles, then 0.
  - All other outputs are 0 throughout.
  - No cpu_ce while cpu_reset=1.
- RUN mode:
  - RUN, div=3 -> cpu_ce pulses exactly every 4 cycles.
  - cpu_clk toggles on each pulse.
  - After 20 ticks, tick_count=4 (wrapped once at 16).
  - Repeat with div=0 -> cpu_ce high every cycle.
- STEP mode:
  - STEP, btn bounces 1/0 with high periods of 2 cycles, then held high 10 cycles -> exactly one cpu_ce.
  - btn_db rises 6 cycles after the stable high begins.
  - Release and press again -> exactly one more tick. tick_count=2.
- BURST mode, normal:
  - BURST, div=2, burst_len=5, one clean press -> 5 cpu_ce pulses spaced 3 cycles apart.
  - busy=1 from the load cycle until the 5th pulse, then 0.
  - A second press mid-burst adds no ticks.
- BURST mode, edge cases:
  - burst_len=0 with a press -> no cpu_ce, busy stays 0.
  - reset asserted at the 2nd tick of a 5-tick burst -> busy=0 and tick_count=0 next cycle.
  - No further ticks after release.
- Mode changes:
  - RUN div=7 for 20 cycles, then switch to HALT -> no cpu_ce afterwards.
  - Switch back to RUN -> first tick exactly 9 cycles after the mode change (1 cycle for the mode register, then div+1).
